ram_arbiter: RTL and testbench

// Two-requester arbiter in front of the synchronous data RAM (1-cycle read latency, byte-lane
// sel, ce/we). Port m0 is the CPU memory stage and port m1 is the program loader/debug master.

---
 rtl/ram_arbiter.sv | 73 +++++++
 tb/tb_ram_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin two-port arbiter for a 1-cycle-latency synchronous RAM,
// with ownership lock, starvation guard and read-data return routing.
module ram_arbiter #(
  parameter int AW       = 32,
  parameter int MAX_WAIT = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [3:0]    m0_sel,
  input  logic [31:0]   m0_wdata,
  input  logic          m0_lock,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [31:0]   m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [3:0]    m1_sel,
  input  logic [31:0]   m1_wdata,
  input  logic          m1_lock,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [31:0]   m1_rdata,
  output logic          ram_ce_o,
  output logic          ram_we_o,
  output logic [AW-1:0] ram_addr_o,
  output logic [3:0]    ram_sel_o,
  output logic [31:0]   ram_data_o,
  input  logic [31:0]   ram_data_i
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  logic          ptr, lk0, lk1, own0, own1, st0, st1, any, sel1;
  logic [CW-1:0] w0, w1;
  assign st0  = m0_req && w0 == CW'(MAX_WAIT);
  assign st1  = m1_req && w1 == CW'(MAX_WAIT);
  // rst_n gates issue so a reset asserted mid-cycle kills the access at once
  assign any  = rst_n && (m0_req || m1_req);
  assign sel1 = st1 || (!st0 && ((lk1 && m1_req) ||
                (!(lk0 && m0_req) && m1_req && (!m0_req || ptr))));
  assign m0_gnt     = any && !sel1;
  assign m1_gnt     = any && sel1;
  assign ram_ce_o   = any;
  assign ram_we_o   = any && (sel1 ? m1_we : m0_we);
  assign ram_addr_o = !any ? '0 : sel1 ? m1_addr : m0_addr;
  assign ram_sel_o  = !any ? '0 : sel1 ? m1_sel : m0_sel;
  assign ram_data_o = !any ? '0 : sel1 ? m1_wdata : m0_wdata;
  assign m0_rvalid  = own0;
  assign m1_rvalid  = own1;
  assign m0_rdata   = own0 ? ram_data_i : '0;
  assign m1_rdata   = own1 ? ram_data_i : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr  <= 1'b0;
      lk0  <= 1'b0;
      lk1  <= 1'b0;
      own0 <= 1'b0;
      own1 <= 1'b0;
      w0   <= '0;
      w1   <= '0;
    end else begin
      if (any) ptr <= !sel1;
      lk0  <= m0_gnt && m0_lock;
      lk1  <= m1_gnt && m1_lock;
      own0 <= m0_gnt && !m0_we;
      own1 <= m1_gnt && !m1_we;
      w0   <= (m0_req && !m0_gnt) ? (st0 ? w0 : w0 + CW'(1)) : '0;
      w1   <= (m1_req && !m1_gnt) ? (st1 ? w1 : w1 + CW'(1)) : '0;
    end
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed checks of ram_arbiter against a behavioural RAM
// preloaded with word i = 0xC0DE0000 + i.
module tb_ram_arbiter;
  logic        clk, rst_n;
  logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [3:0]  m0_sel, m1_sel;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        ram_ce_o, ram_we_o;
  logic [31:0] ram_addr_o, ram_data_o, ram_data_i;
  logic [3:0]  ram_sel_o;
  logic [31:0] mem [256];
  int n_chk, n_fail;

  ram_arbiter #(.AW(32), .MAX_WAIT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_sel(m0_sel),
    .m0_wdata(m0_wdata), .m0_lock(m0_lock), .m0_gnt(m0_gnt),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_sel(m1_sel),
    .m1_wdata(m1_wdata), .m1_lock(m1_lock), .m1_gnt(m1_gnt),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_ce_o(ram_ce_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_sel_o(ram_sel_o), .ram_data_o(ram_data_o), .ram_data_i(ram_data_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (ram_ce_o) begin
      if (ram_we_o) begin
        for (int b = 0; b < 4; b++)
          if (ram_sel_o[b]) mem[ram_addr_o[9:2]][8*b +: 8] <= ram_data_o[8*b +: 8];
      end else ram_data_i <= mem[ram_addr_o[9:2]];
    end

  task automatic idle;
    {m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock} = '0;
    {m0_addr, m1_addr, m0_wdata, m1_wdata} = '0;
    m0_sel = 4'h0;
    m1_sel = 4'h0;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    idle();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    m0_req = 1'b1; m0_addr = 32'h20;
    m1_req = 1'b1; m1_addr = 32'h40;
    @(negedge clk);
    n_chk += 4;
    if (m0_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_gnt0 got %b want 0", m0_gnt); end
    if (m1_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_gnt1 got %b want 0", m1_gnt); end
    if (ram_ce_o !== 1'b0) begin n_fail++; $display("FAIL reset_ce got %b want 0", ram_ce_o); end
    if (m0_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid0 got %b want 0", m0_rvalid); end
    step();
    rst_n = 1'b1;
    @(negedge clk);
    n_chk += 2;
    if (m0_gnt !== 1'b1) begin n_fail++; $display("FAIL first_contention_gnt0 got %b want 1", m0_gnt); end
    if (m1_gnt !== 1'b0) begin n_fail++; $display("FAIL first_contention_gnt1 got %b want 0", m1_gnt); end
    step();
    idle();
  endtask

  task automatic test_contention;
    logic e0;
    do_reset();
    m0_req = 1'b1; m0_addr = 32'h20;
    m1_req = 1'b1; m1_addr = 32'h40;
    for (int i = 0; i < 4; i++) begin
      e0 = (i % 2 == 0);
      @(negedge clk);
      n_chk += 2;
      if (m0_gnt !== e0) begin n_fail++; $display("FAIL rr_gnt0[%0d] got %b want %b", i, m0_gnt, e0); end
      if (m1_gnt !== !e0) begin n_fail++; $display("FAIL rr_gnt1[%0d] got %b want %b", i, m1_gnt, !e0); end
      if (i > 0) begin
        n_chk += 2;
        if (m0_rvalid !== !e0) begin n_fail++; $display("FAIL rr_rvalid0[%0d] got %b want %b", i, m0_rvalid, !e0); end
        if (e0 && m1_rdata !== 32'hC0DE0010) begin n_fail++; $display("FAIL rr_rdata1[%0d] got %h want c0de0010", i, m1_rdata); end
        if (!e0 && m0_rdata !== 32'hC0DE0008) begin n_fail++; $display("FAIL rr_rdata0[%0d] got %h want c0de0008", i, m0_rdata); end
      end
      step();
    end
    idle();
    @(negedge clk);
    n_chk += 3;
    if (m1_rvalid !== 1'b1) begin n_fail++; $display("FAIL rr_last_rvalid1 got %b want 1", m1_rvalid); end
    if (m1_rdata !== 32'hC0DE0010) begin n_fail++; $display("FAIL rr_last_rdata1 got %h want c0de0010", m1_rdata); end
    if (m0_rvalid !== 1'b0) begin n_fail++; $display("FAIL rr_last_rvalid0 got %b want 0", m0_rvalid); end
    step();
  endtask

  task automatic test_write_read;
    do_reset();
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h10; m1_sel = 4'hF; m1_wdata = 32'hA1B2C3D4;
    @(negedge clk);
    n_chk += 3;
    if (m1_gnt !== 1'b1) begin n_fail++; $display("FAIL wr_gnt1 got %b want 1", m1_gnt); end
    if (ram_we_o !== 1'b1) begin n_fail++; $display("FAIL wr_we got %b want 1", ram_we_o); end
    if (ram_data_o !== 32'hA1B2C3D4) begin n_fail++; $display("FAIL wr_data got %h want a1b2c3d4", ram_data_o); end
    step();
    m1_we = 1'b0;
    @(negedge clk);
    n_chk += 3;
    if (m1_gnt !== 1'b1) begin n_fail++; $display("FAIL rd_gnt1 got %b want 1", m1_gnt); end
    if (ram_we_o !== 1'b0) begin n_fail++; $display("FAIL rd_we got %b want 0", ram_we_o); end
    if (m1_rvalid !== 1'b0) begin n_fail++; $display("FAIL wr_no_rvalid got %b want 0", m1_rvalid); end
    step();
    idle();
    @(negedge clk);
    n_chk += 5;
    if (m1_rvalid !== 1'b1) begin n_fail++; $display("FAIL rd_rvalid1 got %b want 1", m1_rvalid); end
    if (m1_rdata !== 32'hA1B2C3D4) begin n_fail++; $display("FAIL rd_rdata1 got %h want a1b2c3d4", m1_rdata); end
    if (m0_rvalid !== 1'b0) begin n_fail++; $display("FAIL rd_rvalid0 got %b want 0", m0_rvalid); end
    if (m0_rdata !== 32'h0) begin n_fail++; $display("FAIL rd_rdata0 got %h want 0", m0_rdata); end
    if (ram_ce_o !== 1'b0) begin n_fail++; $display("FAIL rd_idle_ce got %b want 0", ram_ce_o); end
    step();
  endtask

  task automatic test_lock;
    logic e1;
    do_reset();
    m0_req = 1'b1; m0_lock = 1'b1; m0_addr = 32'h0;
    m1_req = 1'b1; m1_addr = 32'h4;
    for (int c = 1; c <= 10; c++) begin
      e1 = (c == 9);
      @(negedge clk);
      n_chk += 2;
      if (m1_gnt !== e1) begin n_fail++; $display("FAIL lock_gnt1[%0d] got %b want %b", c, m1_gnt, e1); end
      if (m0_gnt !== !e1) begin n_fail++; $display("FAIL lock_gnt0[%0d] got %b want %b", c, m0_gnt, !e1); end
      step();
    end
    idle();
  endtask

  task automatic test_cancel;
    do_reset();
    m0_req = 1'b1; m0_lock = 1'b1;
    m1_req = 1'b1; m1_addr = 32'h8;
    @(negedge clk);
    n_chk += 2;
    if (m0_gnt !== 1'b1) begin n_fail++; $display("FAIL cancel_gnt0_c1 got %b want 1", m0_gnt); end
    if (m1_gnt !== 1'b0) begin n_fail++; $display("FAIL cancel_gnt1_c1 got %b want 0", m1_gnt); end
    step();
    m1_req = 1'b0;
    @(negedge clk);
    n_chk += 2;
    if (m0_gnt !== 1'b1) begin n_fail++; $display("FAIL cancel_gnt0_c2 got %b want 1", m0_gnt); end
    if (m1_gnt !== 1'b0) begin n_fail++; $display("FAIL cancel_gnt1_c2 got %b want 0", m1_gnt); end
    step();
    idle();
    @(negedge clk);
    n_chk += 3;
    if (ram_ce_o !== 1'b0) begin n_fail++; $display("FAIL cancel_ce got %b want 0", ram_ce_o); end
    if (m1_gnt !== 1'b0) begin n_fail++; $display("FAIL cancel_gnt1_c3 got %b want 0", m1_gnt); end
    if (dut.w1 !== 0) begin n_fail++; $display("FAIL cancel_wait1 got %0d want 0", dut.w1); end
    step();
  endtask

  task automatic test_async_reset;
    do_reset();
    m0_req = 1'b1; m0_addr = 32'h20;
    @(negedge clk);
    n_chk += 1;
    if (m0_gnt !== 1'b1) begin n_fail++; $display("FAIL arst_gnt0 got %b want 1", m0_gnt); end
    #1;
    rst_n = 1'b0;
    #1;
    n_chk += 2;
    if (ram_ce_o !== 1'b0) begin n_fail++; $display("FAIL arst_ce got %b want 0", ram_ce_o); end
    if (m0_gnt !== 1'b0) begin n_fail++; $display("FAIL arst_gnt0_low got %b want 0", m0_gnt); end
    step();
    m0_req = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_chk += 2;
      if (m0_rvalid !== 1'b0) begin n_fail++; $display("FAIL arst_rvalid0[%0d] got %b want 0", i, m0_rvalid); end
      if (m0_rdata !== 32'h0) begin n_fail++; $display("FAIL arst_rdata0[%0d] got %h want 0", i, m0_rdata); end
      step();
    end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    ram_data_i = '0;
    for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE0000 + i;
    idle();
    rst_n = 1'b0;
    step();
    test_reset();
    test_contention();
    test_write_read();
    test_lock();
    test_cancel();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
